// File: rtl/frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frame_buf_ctrl
//  Brief    : Double-buffered frame controller. The host fills the back
//             buffer while the display scans the front buffer. The two
//             buffers exchange roles at a frame boundary once the back
//             buffer holds a complete frame.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_buf_ctrl #(
  parameter int FRAME_PIXELS = 10000,
  parameter int ADDR_W       = 20
) (
  input  logic              clk,
  input  logic              reset,

  // Host write side
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,

  // Display request
  input  logic              scan_en,

  // Buffer 0 / buffer 1 control
  output logic              RE0,
  output logic              WE0,
  output logic              RE1,
  output logic              WE1,
  output logic [ADDR_W-1:0] Addr0,
  output logic [ADDR_W-1:0] Addr1,
  output logic [31:0]       WData0,
  output logic [31:0]       WData1,

  // Buffer read data, valid one cycle after the matching RE
  input  logic [7:0]        R0,
  input  logic [7:0]        G0,
  input  logic [7:0]        B0,
  input  logic [7:0]        R1,
  input  logic [7:0]        G1,
  input  logic [7:0]        B1,

  // Display pixel output
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_valid,
  output logic              frame_end,
  output logic              swap
);

  // Last pixel address of a frame and the counter increment.
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] C_ONE       = ADDR_W'(1);

  // --------------------------------------------------------------------------
  // Controller state
  // --------------------------------------------------------------------------
  logic              front_sel_q,   front_sel_d;    // index of the scanned buffer
  logic              front_valid_q, front_valid_d;  // front holds a full frame
  logic              back_full_q,   back_full_d;    // back frame complete, waiting
  logic [ADDR_W-1:0] wr_addr_q,     wr_addr_d;      // next host write address
  logic [ADDR_W-1:0] rd_addr_q,     rd_addr_d;      // next display read address

  // Read-return tracking: one read in flight, tagged with its buffer so the
  // returned pixel comes from the right buffer even across a role exchange.
  logic              rd_pend_q,     rd_pend_d;
  logic              rd_sel_q,      rd_sel_d;
  logic [23:0]       pix_hold_q,    pix_hold_d;     // last delivered pixel {B,G,R}

  // --------------------------------------------------------------------------
  // Combinational events
  // --------------------------------------------------------------------------
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_last_wr;
  logic              w_last_rd;
  logic              w_frame_end;
  logic              w_swap;
  logic [23:0]       w_rd_pix;

  // Decode the per-cycle transfer events; nothing fires while in reset.
  always_comb begin
    w_last_wr   = (wr_addr_q == C_LAST_ADDR);
    w_last_rd   = (rd_addr_q == C_LAST_ADDR);
    w_wr_fire   = !reset && wr_valid && !back_full_q;
    w_rd_fire   = !reset && front_valid_q && scan_en;
    w_frame_end = w_rd_fire && w_last_rd;
    // A full back frame takes over either immediately (nothing on display)
    // or exactly at the end of the frame currently being scanned. A back
    // frame that completes in the same cycle as frame_end is not yet marked
    // full, so the front repeats one more frame before the exchange.
    w_swap      = !reset && back_full_q && (!front_valid_q || w_frame_end);
    w_rd_pix    = rd_sel_q ? {B1, G1, R1} : {B0, G0, R0};
  end

  // Next-state logic for the frame bookkeeping and read pipeline.
  always_comb begin
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    back_full_d   = back_full_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    rd_pend_d     = w_rd_fire;
    rd_sel_d      = front_sel_q;
    pix_hold_d    = rd_pend_q ? w_rd_pix : pix_hold_q;

    if (w_wr_fire) begin
      if (w_last_wr) begin
        wr_addr_d   = '0;
        back_full_d = 1'b1;
      end else begin
        wr_addr_d   = wr_addr_q + C_ONE;
      end
    end

    if (w_rd_fire) begin
      rd_addr_d = w_last_rd ? '0 : (rd_addr_q + C_ONE);
    end

    // Role exchange overrides: the new front starts scanning from pixel 0.
    // No write can be accepted in this cycle since back_full is set.
    if (w_swap) begin
      front_sel_d   = !front_sel_q;
      front_valid_d = 1'b1;
      back_full_d   = 1'b0;
      rd_addr_d     = '0;
    end
  end

  // State register with synchronous reset; buffer contents are untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      back_full_q   <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_sel_q      <= 1'b0;
      pix_hold_q    <= '0;
    end else begin
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      back_full_q   <= back_full_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      rd_pend_q     <= rd_pend_d;
      rd_sel_q      <= rd_sel_d;
      pix_hold_q    <= pix_hold_d;
    end
  end

  // Route the write to the back buffer and the read to the front buffer.
  // Since front and back are always different buffers, a single buffer never
  // sees RE and WE together; idle buffers get zero address and data.
  always_comb begin
    RE0    = 1'b0;
    WE0    = 1'b0;
    RE1    = 1'b0;
    WE1    = 1'b0;
    Addr0  = '0;
    Addr1  = '0;
    WData0 = '0;
    WData1 = '0;

    if (w_wr_fire) begin
      if (front_sel_q) begin
        WE0    = 1'b1;
        Addr0  = wr_addr_q;
        WData0 = wr_data;
      end else begin
        WE1    = 1'b1;
        Addr1  = wr_addr_q;
        WData1 = wr_data;
      end
    end

    if (w_rd_fire) begin
      if (front_sel_q) begin
        RE1   = 1'b1;
        Addr1 = rd_addr_q;
      end else begin
        RE0   = 1'b1;
        Addr0 = rd_addr_q;
      end
    end
  end

  // Host handshake, pixel output and event pulses, all forced low in reset.
  always_comb begin
    wr_ready  = !reset && !back_full_q;
    frame_end = w_frame_end;
    swap      = w_swap;
    pix_valid = !reset && rd_pend_q;
    pix_r     = 8'h00;
    pix_g     = 8'h00;
    pix_b     = 8'h00;
    if (!reset) begin
      if (rd_pend_q) begin
        {pix_b, pix_g, pix_r} = w_rd_pix;
      end else begin
        {pix_b, pix_g, pix_r} = pix_hold_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_buf_ctrl
//  Brief    : Self-checking bench for frame_buf_ctrl with a 4-pixel frame.
//             Two behavioural buffer memories sit on the buffer ports; a
//             frame-level model predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buf_ctrl;

  localparam int C_FP = 4;
  localparam int C_AW = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [31:0]     wr_data = '0;
  logic            scan_en = 1'b0;
  logic            RE0, WE0, RE1, WE1;
  logic [C_AW-1:0] Addr0, Addr1;
  logic [31:0]     WData0, WData1;
  logic [7:0]      R0 = '0, G0 = '0, B0 = '0, R1 = '0, G1 = '0, B1 = '0;
  logic [7:0]      pix_r, pix_g, pix_b;
  logic            pix_valid, frame_end, swap;

  int checks   = 0;
  int failures = 0;

  frame_buf_ctrl #(.FRAME_PIXELS(C_FP), .ADDR_W(C_AW)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .scan_en(scan_en),
    .RE0(RE0), .WE0(WE0), .RE1(RE1), .WE1(WE1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_valid(pix_valid), .frame_end(frame_end), .swap(swap)
  );

  always #5 clk = ~clk;

  // Buffer memories: synchronous write, read data registered one cycle.
  logic [31:0] mem0 [0:C_FP-1];
  logic [31:0] mem1 [0:C_FP-1];
  initial begin
    for (int i = 0; i < C_FP; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
  end
  always @(posedge clk) begin
    if (WE0) mem0[Addr0[1:0]] <= WData0;
    if (WE1) mem1[Addr1[1:0]] <= WData1;
    if (RE0) {B0, G0, R0} <= mem0[Addr0[1:0]][23:0];
    if (RE1) {B1, G1, R1} <= mem1[Addr1[1:0]][23:0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // --------------------------------------------------------------------------
  // Frame-level model: which buffer is on display, whether a full frame is
  // waiting, the pixel counters, and a mirror of every pixel the host wrote.
  // --------------------------------------------------------------------------
  int          m_front = 0;
  bit          m_fv = 0, m_bf = 0, m_pend = 0;
  int          m_wa = 0, m_ra = 0;
  logic [23:0] m_pend_pix = '0, m_hold = '0;
  logic [23:0] m_mem [0:1][0:C_FP-1];

  always @(negedge clk) begin : p_cmp
    bit          e_rdy, wf, rf, e_fe, e_sw, e_pv;
    bit          e_we [0:1];
    bit          e_re [0:1];
    logic [31:0] e_ad [0:1];
    logic [31:0] e_wd [0:1];
    logic [23:0] e_pix;
    int          back;

    back = 1 - m_front;
    for (int b = 0; b < 2; b++) begin
      e_we[b] = 0; e_re[b] = 0; e_ad[b] = '0; e_wd[b] = '0;
    end
    if (reset) begin
      e_rdy = 0; wf = 0; rf = 0; e_fe = 0; e_sw = 0; e_pv = 0; e_pix = '0;
    end else begin
      e_rdy = !m_bf;
      wf    = wr_valid && e_rdy;
      rf    = m_fv && scan_en;
      e_fe  = rf && (m_ra == C_FP - 1);
      e_sw  = m_bf && (!m_fv || e_fe);
      e_pv  = m_pend;
      e_pix = m_pend ? m_pend_pix : m_hold;
      if (wf) begin e_we[back] = 1; e_ad[back] = m_wa; e_wd[back] = wr_data; end
      if (rf) begin e_re[m_front] = 1; e_ad[m_front] = m_ra; end
    end

    chk1("wr_ready", wr_ready, e_rdy);
    chk1("WE0", WE0, e_we[0]);
    chk1("WE1", WE1, e_we[1]);
    chk1("RE0", RE0, e_re[0]);
    chk1("RE1", RE1, e_re[1]);
    chk("Addr0", 32'(Addr0), e_ad[0]);
    chk("Addr1", 32'(Addr1), e_ad[1]);
    chk("WData0", WData0, e_wd[0]);
    chk("WData1", WData1, e_wd[1]);
    chk1("frame_end", frame_end, e_fe);
    chk1("swap", swap, e_sw);
    chk1("pix_valid", pix_valid, e_pv);
    chk("pix_bgr", {8'h00, pix_b, pix_g, pix_r}, {8'h00, e_pix});

    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      m_front = 0; m_fv = 0; m_bf = 0; m_wa = 0; m_ra = 0;
      m_pend = 0; m_hold = '0;
    end else begin
      if (m_pend) m_hold = m_pend_pix;
      m_pend = rf;
      if (rf) begin
        m_pend_pix = m_mem[m_front][m_ra];
        m_ra = (m_ra + 1) % C_FP;
      end
      if (wf) begin
        m_mem[back][m_wa] = wr_data[23:0];
        if (m_wa == C_FP - 1) m_bf = 1;
        m_wa = (m_wa + 1) % C_FP;
      end
      if (e_sw) begin
        m_front = back; m_fv = 1; m_bf = 0; m_ra = 0;
      end
    end
  end

  // One cycle of stimulus; returns mid-cycle so outputs can be inspected.
  task automatic go(input logic r, input logic v, input logic [31:0] d, input logic s);
    @(posedge clk);
    #1;
    reset = r; wr_valid = v; wr_data = d; scan_en = s;
    @(negedge clk);
  endtask

  initial begin : p_watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : p_stim
    // Reset with a write offered: it must be refused.
    for (int i = 0; i < 3; i++) go(1, 1, 32'h12345678, 1);
    chk1("lit_rst_ready", wr_ready, 1'b0);
    chk1("lit_rst_we1", WE1, 1'b0);
    chk("lit_rst_pix", {8'h00, pix_b, pix_g, pix_r}, 32'h0);

    // First frame into buffer 1.
    for (int i = 0; i < 4; i++) begin
      go(0, 1, 32'h000A0B0C + i, 0);
      chk1("lit_w1_we1", WE1, 1'b1);
      chk("lit_w1_addr1", 32'(Addr1), i);
    end
    go(0, 0, 0, 0);
    chk1("lit_first_swap", swap, 1'b1);
    chk1("lit_first_ready", wr_ready, 1'b0);

    // Scan buffer 1 with no new frame pending; it rescans afterwards.
    for (int i = 0; i < 4; i++) begin
      go(0, 0, 0, 1);
      chk1("lit_a_re1", RE1, 1'b1);
      chk("lit_a_addr1", 32'(Addr1), i);
      chk1("lit_a_fe", frame_end, i == 3);
      if (i == 1) begin
        chk1("lit_a_pv", pix_valid, 1'b1);
        chk("lit_a_pixr", 32'(pix_r), 32'h0C);
      end
    end
    go(0, 0, 0, 0);
    chk("lit_a_lastpix", 32'(pix_r), 32'h0F);

    // Second frame into buffer 0.
    for (int i = 0; i < 4; i++) begin
      go(0, 1, 32'h00112233 + i, 0);
      chk("lit_w2_addr0", 32'(Addr0), i);
    end

    // Scan: back full until frame_end (swap), then a third frame written
    // so its last word coincides with frame_end (no swap), then a swap at
    // the following frame_end.
    for (int j = 0; j < 12; j++) begin
      if (j < 4)      go(0, 1, 32'hDEAD0000 + j, 1);
      else if (j < 8) go(0, 1, 32'h00445566 + (j - 4), 1);
      else            go(0, 0, 0, 1);
      if (j < 4) chk1("lit_b_ready", wr_ready, 1'b0);
      if (j == 3) chk1("lit_b_swap", swap, 1'b1);
      if (j == 4) begin
        chk1("lit_b_re0", RE0, 1'b1);
        chk("lit_b_addr0", 32'(Addr0), 0);
        chk("lit_b_oldbuf_pix", 32'(pix_r), 32'h0F);
      end
      if (j == 5) chk("lit_b_newbuf_pix", 32'(pix_r), 32'h33);
      if (j == 7) begin
        chk1("lit_c_fe", frame_end, 1'b1);
        chk1("lit_c_noswap", swap, 1'b0);
      end
      if (j == 8) chk("lit_c_rescan", 32'(Addr0), 0);
      if (j == 11) chk1("lit_c_swap", swap, 1'b1);
    end

    // Pause behaviour: scan_en 1,0,1 after an idle cycle.
    go(0, 0, 0, 0);
    go(0, 0, 0, 1);
    chk("lit_d_addr_a", 32'(Addr1), 0);
    chk1("lit_d_pv0", pix_valid, 1'b0);
    go(0, 0, 0, 0);
    chk1("lit_d_held", RE1, 1'b0);
    chk1("lit_d_pv1", pix_valid, 1'b1);
    chk("lit_d_pix", 32'(pix_r), 32'h66);
    go(0, 0, 0, 1);
    chk("lit_d_addr_b", 32'(Addr1), 1);
    chk1("lit_d_pv2", pix_valid, 1'b0);
    chk("lit_d_hold", 32'(pix_r), 32'h66);
    go(0, 0, 0, 0);
    chk1("lit_d_pv3", pix_valid, 1'b1);
    chk("lit_d_pix2", 32'(pix_r), 32'h67);

    // Reset after two writes aborts everything.
    go(0, 1, 32'h00778899, 0);
    go(0, 1, 32'h0077889A, 0);
    chk("lit_e_addr0", 32'(Addr0), 1);
    go(1, 1, 32'h0, 1);
    go(1, 1, 32'h0, 1);
    chk1("lit_e_rst_we0", WE0, 1'b0);
    chk1("lit_e_rst_re1", RE1, 1'b0);
    go(0, 0, 0, 1);
    chk1("lit_e_no_re0", RE0, 1'b0);
    chk1("lit_e_no_re1", RE1, 1'b0);
    chk("lit_e_pix0", 32'(pix_r), 32'h0);
    go(0, 1, 32'h00ABCDEF, 0);
    chk1("lit_e_we1", WE1, 1'b1);
    chk("lit_e_addr1", 32'(Addr1), 0);
    for (int i = 0; i < 3; i++) go(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_buf_ctrl.md
FRAME_BUF_CTRL -- requirements
Module: frame_buf_ctrl

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 10000, pixels per frame (2..2^20).
REQ-002 SHALL have parameter ADDR_W, default 20, buffer address width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid  in  1  host pixel word offered.
REQ-006 SHALL have port wr_ready  out  1  controller accepts the host word this cycle.
REQ-007 SHALL have port wr_data  in  32  host pixel word; [23:16]=B, [15:8]=G, [7:0]=R.
REQ-008 SHALL have port scan_en  in  1  display requests the next pixel.
REQ-009 SHALL have ports RE0/WE0, RE1/WE1  out  1 each  read and write enables of buffers 0 and 1.
REQ-010 SHALL have ports Addr0, Addr1  out  ADDR_W  buffer addresses.
REQ-011 SHALL have ports WData0, WData1  out  32  buffer write data.
REQ-012 SHALL have ports R0,G0,B0,R1,G1,B1  in  8 each  buffer read data, valid one cycle after RE.
REQ-013 SHALL have ports pix_r, pix_g, pix_b  out  8 each  displayed pixel.
REQ-014 SHALL have port pix_valid  out  1  pix_* valid this cycle.
REQ-015 SHALL have port frame_end  out  1  pulse: last pixel of a front frame was issued.
REQ-016 SHALL have port swap  out  1  pulse: front/back roles exchanged at end of this cycle.

Function
REQ-017 SHALL hold state front_sel (front buffer index), front_valid, back_full, wr_addr, rd_addr.
REQ-018 SHALL drive wr_ready = !back_full.
REQ-019 SHALL, on wr_valid && wr_ready, drive WE=1, Addr=wr_addr and WData=wr_data on the back buffer (index !front_sel) in the same cycle.
REQ-020 SHALL increment wr_addr per accepted write; on the accept at FRAME_PIXELS-1 it SHALL wrap wr_addr to 0 and set back_full next cycle.
REQ-021 SHALL issue a read when front_valid && scan_en: RE=1 and Addr=rd_addr on the front buffer; rd_addr increments, wrapping FRAME_PIXELS-1 -> 0.
REQ-022 SHALL hold rd_addr when scan_en=0 (pause, no skipped pixels).
REQ-023 SHALL assert frame_end combinationally in the cycle the read at rd_addr=FRAME_PIXELS-1 is issued.
REQ-024 SHALL assert pix_valid one cycle after each issued read, with pix_* taken from the buffer selected at issue time (registered select), regardless of a swap in between.
REQ-025 SHALL hold pix_* at their last value while pix_valid=0.
REQ-026 SHALL swap when back_full && (!front_valid || frame_end): next cycle front_sel toggles, front_valid=1, back_full=0, rd_addr=0.
REQ-027 SHALL, for a swap with front_valid=0, allow reads from the new front only from the following cycle.
REQ-028 SHALL, when the last write and frame_end coincide, not swap that cycle; the current front repeats one full frame.
REQ-029 SHALL, without a pending back frame at frame_end, rescan the same front buffer from address 0.
REQ-030 SHALL never assert RE and WE on the same buffer in one cycle.
REQ-031 SHALL drive unused Addr/WData to 0 and unused RE/WE to 0.

Reset
REQ-032 SHALL, while reset=1, clear front_sel, front_valid, back_full, wr_addr and rd_addr.
REQ-033 SHALL, while reset=1, drive all RE/WE, pix_valid, frame_end and swap to 0, and pix_* to 0.
REQ-034 SHALL drive wr_ready=0 while reset=1, with wr_valid ignored.
REQ-035 SHALL abort in-flight frames on reset mid-operation; buffer contents are not cleared.

Verification (FRAME_PIXELS=4)
REQ-036 SHALL cover the post-reset write of 4 words 0x000A0B0C.. -> WE1 at Addr1 0..3, back_full, swap pulse, front_sel=1, front_valid=1.
REQ-037 SHALL cover scan_en=1 for 4 cycles after the first swap -> RE1 at Addr1 0,1,2,3, frame_end with Addr1=3, pix_valid 1 cycle later, pix_r=0x0C on the first pixel.
REQ-038 SHALL cover the second frame completing mid-scan -> wr_ready=0 until frame_end; swap in the frame_end cycle; next read on buffer 0 at Addr0=0.
REQ-039 SHALL cover the last write coinciding with frame_end -> no swap; front rescans from 0; swap at the next frame_end.
REQ-040 SHALL cover scan_en toggled 1,0,1 -> Addr 0, (held), 1; pix_valid pattern 0,1,0,1.
REQ-041 SHALL cover reset asserted after 2 writes -> wr_addr=0, front_valid=0, all enables 0; the next write lands at address 0.
